clkdiv_multi: RTL and testbench
===============================

# clkdiv_multi

Parametrised multi-channel clock divider that generates NCH independent divided clock-enable waveforms from one system clock. Each channel has a runtime-programmable half-period with glitch-free shadowed updates, a per-channel enable, and a one-cycle tick strobe. It sits between the board clock and the slow-rate logic (display scan, debounce, 1 Hz counters), and replaces the fixed divide-by-constant divider.

## Interface

Parameters:
- NCH, 4, number of channels (1..16)
- CW, 32, counter/divisor width
- DEFAULT_DIV, 50000000, reset half-period in clk cycles (1 Hz from 100 MHz); must be < 2^CW

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  NCH  per-channel run enable
- div_wr  in  1  write strobe for the pending divisor
- div_sel  in  $clog2(NCH) (min 1)  target channel for div_wr
- div_data  in  CW  new half-period value H
- clk_out  out  NCH  divided square wave per channel, registered
- tick  out  NCH  one-cycle strobe per channel, registered

## Operation

- Per channel, state: cnt[CW], active[CW], pending[CW], clk_out, tick.
- Effective half-period: Heff = (active == 0) ? 1 : active. Output period = 2·Heff clk cycles, 50% duty.
- Running (en[i]=1): if cnt == Heff−1 → terminal count: cnt←0, clk_out toggles, active←pending; else cnt←cnt+1.
- tick[i] = 1 for exactly the cycle in which clk_out[i] is first high after a 0→1 toggle; 0 otherwise.
- Stopped (en[i]=0): cnt←0, clk_out←0, tick←0, active←pending.
- div_wr=1: pending[div_sel]←div_data. If div_sel ≥ NCH, the write is ignored.
- A running channel changes period only at a terminal count, never mid-half-period.
- Write coincident with a terminal count on the same channel: active takes the old pending value. The new value applies at the following terminal count.
- Channels are fully independent. One write touches one channel only.

## Timing

- Reset (rst=0, asynchronous): cnt=0, clk_out=0, tick=0, active=pending=DEFAULT_DIV, on all channels.
- After rst deasserts with en=1, the first clk_out rise happens on the Heff-th rising clk edge. The following edge changes level after another Heff edges.
- Enable rise: same as after reset. The first toggle occurs Heff cycles after the edge that samples en=1.
- Enable fall: clk_out and tick are 0 from the next edge. No partial pulse is ever extended.
- div_wr to pending: 1-cycle latency. Pending to active: at the next terminal count, or on the next edge if the channel is stopped.
- Heff=1 gives clk/2 with tick every 2 cycles. cnt never exceeds Heff−1. There is no wrap-around.
- rst assertion mid-period: all outputs go to 0 immediately. Previously written divisors are lost.

## Configuration

- CLKDIV_SYNC_EN defined: adds an input port `sync` (1 bit) after `en`. When sync=1 on an edge, every channel does cnt←0, clk_out←0, tick←0, active←pending, whatever the state of en. This phase-aligns all channels. If sync and div_wr occur in the same cycle, active takes the old pending value.
- CLKDIV_SYNC_EN undefined: the `sync` port and its logic are absent. Channels align only via reset or enable.

## Structure

- Package clkdiv_pkg holds: DEFAULT_DIV default constant, a CW default constant, and a function heff(x) that returns 1 for x==0 and x otherwise.
- One sub-module, clkdiv_channel (ports: clk, rst, en, sync when enabled, wr, data, clk_out, tick), holds the per-channel state.
- The top decodes div_sel into per-channel wr and instantiates NCH channels in a generate loop.

## Test plan

- Reset: hold rst=0 with DEFAULT_DIV=4. Expect clk_out=0, tick=0 on all channels. Release with en=all 1 → first clk_out rise on the 4th edge, period 8, tick high 1 cycle every 8.
- Runtime change: channel 0 runs at H=3. Write H=5 mid-half-period → current half-period stays 3 cycles. From the next terminal count the half-period is 5.
- Edge values: write H=0 and H=1 → both give period 2 with tick every 2 cycles. Write with div_sel=NCH → no channel changes.
- Collision: div_wr to channel 1 on its terminal-count cycle with H 2→6 → one more half-period of 2, then 6.
- Enable/reset mid-run: drop en[2] while clk_out=1 → 0 on the next edge. Re-raise → rise after Heff cycles. Assert rst mid-period → outputs 0 asynchronously.
- CLKDIV_SYNC_EN: channels at H=3 and H=5 have drifted in phase. Pulse sync → both at 0, then rising edges at +3 and +5 cycles. Build without the macro → the bench compiles without a sync port.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// clkdiv_multi shared constants and helpers.
// Used by the channel, the top and the write-bus interface.
package clkdiv_pkg;

  localparam int CW_DEF = 32;
  localparam int unsigned DIV_DEF = 50000000;

  // Wide enough for any supported counter width.
  localparam int HW = 64;

  // A programmed half-period of zero behaves as one.
  function automatic logic [HW-1:0] heff(
    input logic [HW-1:0] x
  );
    return (x == '0) ? HW'(1) : x;
  endfunction

  // Width of the channel select field (at least one bit).
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_if.sv
// clkdiv_multi divisor write bus.
// master drives a write, slave (the divider) consumes it.
interface clkdiv_if
  import clkdiv_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = CW_DEF
);

  localparam int SW = sel_w(NCH);

  logic          div_wr;
  logic [SW-1:0] div_sel;
  logic [CW-1:0] div_data;

  modport master (
    output div_wr,
    output div_sel,
    output div_data
  );

  modport slave (
    input div_wr,
    input div_sel,
    input div_data
  );

endinterface

// File: rtl/clkdiv_multi_channel.sv
// clkdiv_multi single channel: counter, shadowed divisor.
// CLKDIV_SYNC_EN adds the phase-align input sync.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int            CW          = CW_DEF,
  parameter logic [CW-1:0] DEFAULT_DIV = CW'(DIV_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
`ifdef CLKDIV_SYNC_EN
  input  logic          sync,
`endif
  input  logic          wr,
  input  logic [CW-1:0] data,
  output logic          clk_out,
  output logic          tick
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] active;
  logic [CW-1:0] pending;
  logic [CW-1:0] h;
  logic          stop;
  logic          term;

  assign h = CW'(heff(HW'(active)));

`ifdef CLKDIV_SYNC_EN
  assign stop = !en || sync;
`else
  assign stop = !en;
`endif

  assign term = (cnt == h - CW'(1));

  // Pending divisor: written by the bus, read at reload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= DEFAULT_DIV;
    end else if (wr) begin
      pending <= data;
    end
  end

  // Counter and output; the active divisor only
  // reloads at a terminal count or while held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      active  <= DEFAULT_DIV;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (stop) begin
      cnt     <= '0;
      active  <= pending;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (term) begin
      cnt     <= '0;
      active  <= pending;
      clk_out <= !clk_out;
      tick    <= !clk_out;
    end else begin
      cnt     <= cnt + CW'(1);
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: NCH independent clock-enable dividers.
// Optional macro CLKDIV_SYNC_EN adds the sync input.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int          NCH         = 4,
  parameter int          CW          = CW_DEF,
  parameter int unsigned DEFAULT_DIV = DIV_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] en,
`ifdef CLKDIV_SYNC_EN
  input  logic           sync,
`endif
  clkdiv_if.slave        bus,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick
);

  localparam int SW = sel_w(NCH);

  logic [NCH-1:0] wr;

  // Steer the write to the addressed channel only;
  // selects past the last channel match nothing.
  always_comb begin
    wr = '0;
    for (int i = 0; i < NCH; i++) begin
      wr[i] = bus.div_wr && (bus.div_sel == SW'(i));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clkdiv_channel #(
      .CW          (CW),
      .DEFAULT_DIV (CW'(DEFAULT_DIV))
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[g]),
`ifdef CLKDIV_SYNC_EN
      .sync    (sync),
`endif
      .wr      (wr[g]),
      .data    (bus.div_data),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Bench for clkdiv_multi: vector table, directed
// corner cases and random traffic against a model.
module tb_clkdiv_multi;

  localparam int          NCH  = 3;
  localparam int          CW   = 8;
  localparam int          SW   = 2;
  localparam int unsigned DDIV = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] en;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
`ifdef CLKDIV_SYNC_EN
  logic           sync;
`endif

  clkdiv_if #(.NCH(NCH), .CW(CW)) bus ();

  clkdiv_multi #(
    .NCH         (NCH),
    .CW          (CW),
    .DEFAULT_DIV (DDIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
`ifdef CLKDIV_SYNC_EN
    .sync    (sync),
`endif
    .bus     (bus),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(
    input string nm, input int got, input int exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t",
               nm, got, exp, $time);
    end
  endfunction

  // Model: each channel keeps the absolute edge number of
  // its next toggle rather than a running count.
  int unsigned t;
  int unsigned m_pend [NCH];
  int unsigned m_nxt  [NCH];
  bit          m_lvl  [NCH];
  bit          m_tk   [NCH];

  function automatic int unsigned hf(input int unsigned x);
    return (x == 0) ? 1 : x;
  endfunction

  function automatic void model_reset();
    t = 0;
    for (int i = 0; i < NCH; i++) begin
      m_pend[i] = DDIV;
      m_nxt[i]  = hf(DDIV);
      m_lvl[i]  = 1'b0;
      m_tk[i]   = 1'b0;
    end
  endfunction

  function automatic void model_step();
    bit s;
    s = 1'b0;
`ifdef CLKDIV_SYNC_EN
    s = sync;
`endif
    t++;
    for (int i = 0; i < NCH; i++) begin
      if (!en[i] || s) begin
        m_lvl[i] = 1'b0;
        m_tk[i]  = 1'b0;
        m_nxt[i] = t + hf(m_pend[i]);
      end else if (t == m_nxt[i]) begin
        m_lvl[i] = !m_lvl[i];
        m_tk[i]  = m_lvl[i];
        m_nxt[i] = t + hf(m_pend[i]);
      end else begin
        m_tk[i]  = 1'b0;
      end
      if (bus.div_wr && int'(bus.div_sel) == i)
        m_pend[i] = int'(bus.div_data);
    end
  endfunction

  function automatic int m_out();
    int v;
    v = 0;
    for (int i = 0; i < NCH; i++)
      if (m_lvl[i]) v = v | (1 << i);
    return v;
  endfunction

  function automatic int m_tick();
    int v;
    v = 0;
    for (int i = 0; i < NCH; i++)
      if (m_tk[i]) v = v | (1 << i);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_out", int'(clk_out), m_out());
    chk("model_tick", int'(tick), m_tick());
  endtask

  task automatic wr_step(input int s, input int d);
    bus.div_wr   = 1'b1;
    bus.div_sel  = SW'(s);
    bus.div_data = CW'(d);
    step();
    bus.div_wr   = 1'b0;
  endtask

  task automatic wait_toggle(input int ch, output int n);
    logic p;
    p = clk_out[ch];
    n = 0;
    do begin
      step();
      n++;
    end while (clk_out[ch] == p && n < 40);
  endtask

  task automatic count_ticks(
    input int ch, input int cyc, output int n
  );
    n = 0;
    repeat (cyc) begin
      step();
      if (tick[ch]) n++;
    end
  endtask

  typedef struct {
    logic [NCH-1:0] en;
    logic [NCH-1:0] out;
    logic [NCH-1:0] tk;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    int r0;
    int r1;
    logic p;

    tbl[0]  = '{3'b111, 3'b000, 3'b000};
    tbl[1]  = '{3'b111, 3'b000, 3'b000};
    tbl[2]  = '{3'b111, 3'b000, 3'b000};
    tbl[3]  = '{3'b111, 3'b111, 3'b111};
    tbl[4]  = '{3'b111, 3'b111, 3'b000};
    tbl[5]  = '{3'b111, 3'b111, 3'b000};
    tbl[6]  = '{3'b111, 3'b111, 3'b000};
    tbl[7]  = '{3'b111, 3'b000, 3'b000};
    tbl[8]  = '{3'b111, 3'b000, 3'b000};
    tbl[9]  = '{3'b111, 3'b000, 3'b000};
    tbl[10] = '{3'b111, 3'b000, 3'b000};
    tbl[11] = '{3'b011, 3'b011, 3'b011};

    bus.div_wr   = 1'b0;
    bus.div_sel  = '0;
    bus.div_data = '0;
    en  = '0;
    rst = 1'b0;
`ifdef CLKDIV_SYNC_EN
    sync = 1'b0;
`endif

    // Reset held
    repeat (3) begin
      @(negedge clk);
      chk("rst_out", int'(clk_out), 0);
      chk("rst_tick", int'(tick), 0);
    end
    en = '1;
    model_reset();
    rst = 1'b1;

    // Default half-period 4 after release
    for (int i = 0; i < 12; i++) begin
      en = tbl[i].en;
      step();
      chk("tbl_out", int'(clk_out), int'(tbl[i].out));
      chk("tbl_tick", int'(tick), int'(tbl[i].tk));
    end
    en = '1;

    // Runtime change on ch0: 3 then 5
    wr_step(0, 3);
    en = 3'b110;
    step();
    en = '1;
    wait_toggle(0, n);
    chk("ch0_h3", n, 3);
    wr_step(0, 5);
    wait_toggle(0, n);
    chk("ch0_keep3", n + 1, 3);
    wait_toggle(0, n);
    chk("ch0_h5a", n, 5);
    wait_toggle(0, n);
    chk("ch0_h5b", n, 5);

    // H=0 and H=1 both give clk/2
    wr_step(1, 0);
    wr_step(2, 1);
    en = 3'b001;
    step();
    en = '1;
    wait_toggle(1, n);
    chk("ch1_h0a", n, 1);
    wait_toggle(1, n);
    chk("ch1_h0b", n, 1);
    count_ticks(1, 8, n);
    chk("ch1_ticks", n, 4);
    count_ticks(2, 8, n);
    chk("ch2_ticks", n, 4);

    // Out-of-range select writes nothing
    wr_step(3, 9);
    en = 3'b000;
    step();
    en = '1;
    wait_toggle(0, n);
    chk("bad_sel_ch0", n, 5);
    wait_toggle(1, n);
    chk("bad_sel_ch1", n, 1);
    wait_toggle(2, n);
    chk("bad_sel_ch2", n, 1);

    // Write on ch1 terminal count: 2 -> 6
    wr_step(1, 2);
    en = 3'b101;
    step();
    en = '1;
    wait_toggle(1, n);
    chk("ch1_h2", n, 2);
    step();
    p = clk_out[1];
    wr_step(1, 6);
    chk("coll_toggle", int'(clk_out[1]), int'(!p));
    wait_toggle(1, n);
    chk("coll_old", n, 2);
    wait_toggle(1, n);
    chk("coll_new", n, 6);

    // Enable drop while high, then re-raise
    wr_step(2, 4);
    for (int k = 0; k < 10 && !clk_out[2]; k++) step();
    chk("ch2_high", int'(clk_out[2]), 1);
    en = 3'b011;
    step();
    chk("en_drop_out", int'(clk_out[2]), 0);
    chk("en_drop_tick", int'(tick[2]), 0);
    step();
    chk("en_hold_out", int'(clk_out[2]), 0);
    en = '1;
    wait_toggle(2, n);
    chk("en_rise", n, 4);

    // Asynchronous reset mid-period
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out", int'(clk_out), 0);
    chk("arst_tick", int'(tick), 0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b1;
    wait_toggle(0, n);
    chk("arst_ch0", n, 4);
    wait_toggle(1, n);
    chk("arst_ch1", n, 4);

`ifdef CLKDIV_SYNC_EN
    // Re-align drifted channels
    wr_step(0, 3);
    wr_step(1, 5);
    en = 3'b100;
    step();
    en = '1;
    repeat (7) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_out", int'(clk_out[1:0]), 0);
    r0 = 0;
    r1 = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (r0 == 0 && clk_out[0]) r0 = k;
      if (r1 == 0 && clk_out[1]) r1 = k;
    end
    chk("sync_ch0", r0, 3);
    chk("sync_ch1", r1, 5);
`else
    r0 = 0;
    r1 = 0;
`endif

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      en = '1;
      if ($urandom_range(9) == 0) en = NCH'($urandom);
      bus.div_wr   = ($urandom_range(3) == 0);
      bus.div_sel  = SW'($urandom_range(3));
      bus.div_data = CW'($urandom_range(6));
`ifdef CLKDIV_SYNC_EN
      sync = ($urandom_range(30) == 0);
`endif
      step();
    end
    bus.div_wr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
